// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoder.
// Registered grant bus, bounded hold time and a one-cycle gap between grants.
module rr_grant_ctrl #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_sel,
    output logic       gnt_en,
    output logic       busy,
    output logic       ovr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [HOLD_W-1:0] r_cnt;
    logic [3:0]        r_gnt;
    logic [1:0]        r_sel;
    logic              r_en;
    logic              r_busy;
    logic              r_ovr;

    logic              w_any;
    logic [1:0]        w_win;
    logic [3:0]        w_win_oh;
    logic              w_cur_req;
    logic              w_expired;
    logic [1:0]        w_next_ptr;

    // Rotating search from the pointer; first asserted request wins.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        w_win = r_ptr;
        found = 1'b0;
        idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!found && req[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    // Release conditions and decoded winner for the current cycle.
    always_comb begin
        w_any      = |req;
        w_win_oh   = 4'b0001 << w_win;
        w_cur_req  = req[r_sel];
        w_expired  = (r_cnt == HOLD_LAST);
        w_next_ptr = r_sel + 2'd1;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_GAP: begin
                    r_ovr <= 1'b0;
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_sel   <= w_win;
                        r_gnt   <= w_win_oh;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= 4'b0000;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (!w_cur_req || w_expired) begin
                        r_state <= S_GAP;
                        r_gnt   <= 4'b0000;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        // A dropping request wins over expiry: no overrun pulse.
                        r_ovr   <= w_cur_req;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_ovr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ovr   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_sel = r_sel;
    assign gnt_en  = r_en;
    assign busy    = r_busy;
    assign ovr     = r_ovr;

endmodule
